// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared definitions for the CORDIC rotation core and the
//               display stage downstream of it. Holds the 3-bit status codes,
//               the pre-scaled start vector, the legal angle limit, and the
//               Q.14 arctangent table.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    // Status codes. The display stage decodes these same values.
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] ERR  = 3'd5;
    localparam logic [2:0] DONE = 3'd6;

    // 1/K in Q.14. Pre-scaling the start vector makes the final magnitude
    // unity, so no gain correction is needed after the last micro-rotation.
    localparam int K_INIT  = 9949;
    // pi/2 in Q.14. This is the largest angle magnitude the core accepts.
    localparam int HALF_PI = 25736;

    localparam int ATAN_ENTRIES = 14;

    // atan(2^-i) in Q.14. Indices outside the table return 0.
    function automatic logic [17:0] atan_q14(input logic [3:0] idx);
        logic [17:0] v;
        case (idx)
            4'd0:    v = 18'd12868;
            4'd1:    v = 18'd7596;
            4'd2:    v = 18'd4014;
            4'd3:    v = 18'd2037;
            4'd4:    v = 18'd1023;
            4'd5:    v = 18'd512;
            4'd6:    v = 18'd256;
            4'd7:    v = 18'd128;
            4'd8:    v = 18'd64;
            4'd9:    v = 18'd32;
            4'd10:   v = 18'd16;
            4'd11:   v = 18'd8;
            4'd12:   v = 18'd4;
            4'd13:   v = 18'd2;
            default: v = 18'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ============================================================================
// Module      : cordic_atan_rom
// Description : Combinational arctangent lookup, atan(2^-i) in Q.14.
//   i_idx  : iteration index (0..13 valid, higher indices return 0)
//   o_atan : table entry, zero-extended or truncated to WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_atan_rom #(
    parameter int WIDTH = 18
) (
    input  logic [3:0]       i_idx,
    output logic [WIDTH-1:0] o_atan
);
    import cordic_pkg::*;

    always_comb begin
        o_atan = WIDTH'(atan_q14(i_idx));
    end

endmodule
`default_nettype wire

// File: rtl/cordic_rotation_core.sv
`default_nettype none
// ============================================================================
// Module      : cordic_rotation_core
// Description : Iterative rotation-mode CORDIC. Computes sin/cos of a signed
//               Q.14 radian angle, one micro-rotation per clock.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request a computation (accepted in IDLE, DONE or ERR)
//   angle      : signed Q.14 angle, |angle| <= pi/2
//   sel        : output select, 0 = sin, 1 = cos
//   busy       : high in LOAD and RUN
//   done       : one-cycle pulse on the first DONE cycle
//   state      : 3-bit status code for the display stage
//   result     : |selected value| in Q.14, zero-extended to 32 bits
//   result_neg : selected value is negative
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_rotation_core #(
    parameter int ITER  = 14,
    parameter int WIDTH = 18,
    parameter int FRAC  = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] angle,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state,
    output logic [31:0]      result,
    output logic             result_neg
);
    import cordic_pkg::*;

    // The constant tables are Q.14; other fractions need regenerated tables.
    generate
        if (ITER < 1 || ITER > ATAN_ENTRIES || FRAC != 14) begin : g_bad_params
            $error("cordic_rotation_core: ITER must be 1..14 and FRAC must be 14");
        end
    endgenerate

    localparam logic signed [WIDTH-1:0] c_half_pi     = WIDTH'(HALF_PI);
    localparam logic signed [WIDTH-1:0] c_neg_half_pi = WIDTH'(-HALF_PI);
    localparam logic signed [WIDTH-1:0] c_k_init      = WIDTH'(K_INIT);
    localparam logic [3:0]              c_last_iter   = 4'(ITER - 1);

    logic [2:0]              r_state;
    logic [2:0]              w_state_next;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic signed [WIDTH-1:0] r_z;
    logic [3:0]              r_i;
    logic                    r_done;
    logic [31:0]             r_result;
    logic                    r_result_neg;

    logic [WIDTH-1:0]        w_atan;
    logic signed [WIDTH-1:0] w_angle;
    logic                    w_in_range;
    logic                    w_accept;
    logic                    w_dir_pos;
    logic signed [WIDTH-1:0] w_x_sh;
    logic signed [WIDTH-1:0] w_y_sh;
    logic signed [WIDTH-1:0] w_sel_val;
    logic [WIDTH-1:0]        w_mag;

    cordic_atan_rom #(
        .WIDTH (WIDTH)
    ) u_atan_rom (
        .i_idx  (r_i),
        .o_atan (w_atan)
    );

    assign w_angle    = $signed(angle);
    assign w_in_range = (w_angle <= c_half_pi) && (w_angle >= c_neg_half_pi);

    // Rotation direction: z >= 0 rotates counter-clockwise (d = +1).
    assign w_dir_pos = ~r_z[WIDTH-1];
    assign w_x_sh    = r_x >>> r_i;
    assign w_y_sh    = r_y >>> r_i;

    // Output magnitude; |x|,|y| stay far below 2^(WIDTH-1) so negation is safe.
    assign w_sel_val = sel ? r_x : r_y;
    assign w_mag     = w_sel_val[WIDTH-1] ? WIDTH'(-w_sel_val) : WIDTH'(w_sel_val);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    w_accept     = w_in_range;
                    w_state_next = w_in_range ? LOAD : ERR;
                end
            end
            LOAD:    w_state_next = RUN;
            RUN:     if (r_i == c_last_iter) w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == DONE) && (r_state != DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_i          <= '0;
            r_result     <= '0;
            r_result_neg <= 1'b0;
        end else begin
            // The angle is captured into z on acceptance; x and y keep the
            // previous answer until LOAD so DONE outputs stay stable.
            if (w_accept) begin
                r_z <= w_angle;
            end
            case (r_state)
                LOAD: begin
                    r_x <= c_k_init;
                    r_y <= '0;
                    r_i <= '0;
                end
                RUN: begin
                    if (w_dir_pos) begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                        r_z <= r_z - $signed(w_atan);
                    end else begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                        r_z <= r_z + $signed(w_atan);
                    end
                    r_i <= r_i + 4'd1;
                end
                DONE: begin
                    r_result     <= {{(32-WIDTH){1'b0}}, w_mag};
                    r_result_neg <= w_sel_val[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    assign state      = r_state;
    assign busy       = (r_state == LOAD) || (r_state == RUN);
    assign done       = r_done;
    assign result     = r_result;
    assign result_neg = r_result_neg;

endmodule
`default_nettype wire

// File: tb/tb_cordic_rotation_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cordic_rotation_core
// Description : Self-checking bench for cordic_rotation_core. Expected sin/cos
//               values are ideal Q.14 trigonometry with a tolerance; they are
//               queued when a start is driven and popped when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_rotation_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [17:0] angle;
    logic        sel;
    logic        busy;
    logic        done;
    logic [2:0]  state;
    logic [31:0] result;
    logic        result_neg;

    always #5 clk = ~clk;

    cordic_rotation_core #(
        .ITER  (14),
        .WIDTH (18),
        .FRAC  (14)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .angle      (angle),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .state      (state),
        .result     (result),
        .result_neg (result_neg)
    );

    typedef struct {
        logic signed [17:0] angle;
        int exp_sin;
        int tol_sin;
        int exp_cos;
        int tol_cos;
    } vec_t;

    typedef struct {
        int exp_sin;
        int tol_sin;
        int exp_cos;
        int tol_cos;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;
    int   last_cos = 0;
    int   last_cos_tol = 0;

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compares result/result_neg against a signed ideal value. The sign is
    // only checked when the value is clearly away from zero.
    task automatic check_mag(input string name, input int exp, input int tol);
        int  mag;
        int  e;
        bit  ok;
        mag = int'(result);
        e   = (exp < 0) ? -exp : exp;
        ok  = (mag >= e - tol) && (mag <= e + tol);
        if (e > tol && result_neg != (exp < 0)) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got mag %0d neg %0d, expected %0d +/-%0d", name, mag, result_neg, exp, tol);
        end
    endtask

    // Starts at a negedge; returns at a negedge with the core in DONE, sel = 1.
    task automatic run_vec(input vec_t v, input int inj_cycle, input logic signed [17:0] inj_angle);
        int  cyc_done;
        bit  busy_ok;
        sb_t e;
        angle = v.angle;
        sel   = 1'b0;
        start = 1'b1;
        sb_q.push_back('{v.exp_sin, v.tol_sin, v.exp_cos, v.tol_cos});
        @(negedge clk);
        start    = 1'b0;
        cyc_done = 0;
        busy_ok  = 1'b1;
        for (int c = 1; c <= 40 && cyc_done == 0; c++) begin
            if (c == 1) check_eq("load_state", longint'(state), 1);
            if (done) cyc_done = c;
            else if (!busy) busy_ok = 1'b0;
            if (c == inj_cycle) begin
                angle = inj_angle;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (cyc_done == 0) @(negedge clk);
        end
        start = 1'b0;
        check_eq("done_latency", longint'(cyc_done), 16);
        check_eq("busy_window", longint'(busy_ok), 1);
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            if (cyc_done != 0) begin
                check_eq("busy_at_done", longint'(busy), 0);
                check_eq("state_done", longint'(state), 6);
                @(negedge clk);
                check_eq("done_single_pulse", longint'(done), 0);
                check_mag("sin", e.exp_sin, e.tol_sin);
                sel = 1'b1;
                @(negedge clk);
                check_mag("cos", e.exp_cos, e.tol_cos);
                last_cos     = e.exp_cos;
                last_cos_tol = e.tol_cos;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bad;
        vecs[0] = '{18'sd0,       0,      4, 16384, 4};
        vecs[1] = '{18'sd25736,   16384,  4, 0,     8};
        vecs[2] = '{-18'sd8579,   -8192,  4, 14189, 4};
        vecs[3] = '{18'sd12868,   11585, 10, 11585, 10};
        vecs[4] = '{18'sd17157,   14189, 10, 8192,  10};
        vecs[5] = '{-18'sd25736, -16384, 10, 0,     10};
        vecs[6] = '{18'sd4096,    4053,  10, 15875, 10};
        vecs[7] = '{-18'sd16384, -13787, 10, 8852,  10};

        rst   = 1'b1;
        start = 1'b0;
        angle = '0;
        sel   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_state", longint'(state), 0);
        check_eq("reset_busy", longint'(busy), 0);
        check_eq("reset_done", longint'(done), 0);
        check_eq("reset_result", longint'(result), 0);
        check_eq("reset_neg", longint'(result_neg), 0);

        for (int k = 0; k < 8; k++) begin
            run_vec(vecs[k], 0, 18'sd0);
        end

        // Out-of-range angles: ERR, no done, result held from last answer.
        angle = 18'd30000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("err_state", longint'(state), 5);
        check_eq("err_busy", longint'(busy), 0);
        check_mag("err_result_hold", last_cos, last_cos_tol);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || state != 3'd5) bad++;
        end
        check_eq("err_no_done", longint'(bad), 0);
        angle = 18'(-25737);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("err_boundary_neg", longint'(state), 5);
        run_vec(vecs[0], 0, 18'sd0);

        // A start during RUN is dropped; the first angle's answer comes out.
        run_vec(vecs[3], 5, -18'sd8579);

        // Reset in the middle of RUN.
        angle = 18'd17157;
        sel   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrun_rst_state", longint'(state), 0);
        check_eq("midrun_rst_busy", longint'(busy), 0);
        check_eq("midrun_rst_result", longint'(result), 0);
        check_eq("midrun_rst_neg", longint'(result_neg), 0);
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            if (done || state != 3'd0) bad++;
            @(negedge clk);
        end
        check_eq("midrun_rst_no_done", longint'(bad), 0);

        // rst and start together: rst wins.
        rst   = 1'b1;
        start = 1'b1;
        angle = '0;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_eq("rst_start_state", longint'(state), 0);
        check_eq("rst_start_busy", longint'(busy), 0);
        @(negedge clk);
        check_eq("rst_start_idle", longint'(state), 0);
        run_vec(vecs[2], 0, 18'sd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
